// File: rtl/soc_fpga_ram_arb_pkg.sv
// Shared types and constants for the code-RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   gnt_e            - grant encoding driven by the round-robin core
//   LOCKMAX_DEFAULT  - default bound on consecutive locked loader grants
//   WR_ACK_DATA      - data value returned with a loader write acknowledge
package soc_fpga_ram_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_0    = 2'd1,
        GNT_1    = 2'd2
    } gnt_e;

    localparam int LOCKMAX_DEFAULT = 16;

    localparam int WR_ACK_DATA = 0;

endpackage

// File: rtl/soc_fpga_rr_arb2.sv
// Two-way round-robin arbiter holding the "last granted" state.
// Latency: grant is combinational from the requests; state updates on the grant edge.
// Backpressure: a grant is only issued to a valid request, so every grant is a transfer.
//
// Ports:
//   i_clk, i_rst       - clock, asynchronous active-high reset
//   i_req0, i_req1     - request valids
//   i_hold1            - override: requester 1 wins a conflict (burst lock)
//   o_gnt              - grant (GNT_NONE / GNT_0 / GNT_1), GNT_NONE while in reset
//   o_last1            - 1 when requester 1 won the most recent transfer
module soc_fpga_rr_arb2
    import soc_fpga_ram_arb_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_hold1,
    output gnt_e o_gnt,
    output logic o_last1
);

    // Reset to "requester 1 last" so requester 0 wins the first conflict.
    logic r_last1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last1 <= 1'b1;
        end else if (o_gnt != GNT_NONE) begin
            r_last1 <= (o_gnt == GNT_1);
        end
    end

    always_comb begin
        o_gnt = GNT_NONE;
        if (!i_rst) begin
            if (i_req0 && i_req1) begin
                o_gnt = (i_hold1 || !r_last1) ? GNT_1 : GNT_0;
            end else if (i_req0) begin
                o_gnt = GNT_0;
            end else if (i_req1) begin
                o_gnt = GNT_1;
            end
        end
    end

    assign o_last1 = r_last1;

endmodule

// File: rtl/soc_fpga_ram_code_arb.sv
// Arbitrates a read-only fetch port and a read/write loader port onto one RAM port A.
// Latency: request granted combinationally; response one cycle after the transfer.
// Backpressure: requests stall via ReqNReady; responses have no backpressure.
//
// Optional feature: define SOC_FPGA_RAM_ARB_LOCK_EN to compile in the loader burst
// lock (Req1Lock keeps requester 1 ahead for up to LOCKMAX consecutive transfers).
//
// Ports:
//   PortAClk, PortAReset                      - clock, async active-high reset
//   Req0Valid/Req0Ready/Req0Addr              - fetch read request
//   Rsp0Valid/Rsp0Data                        - fetch read response
//   Req1Valid/Req1Ready/Req1Write/Req1Addr/
//   Req1WData/Req1Lock                        - loader request
//   Rsp1Valid/Rsp1Data                        - loader response (read data or write ack)
//   PortAAddr/PortADataIn/PortAWriteEnable    - RAM drive
//   PortADataOut                              - RAM registered read data
module soc_fpga_ram_code_arb
    import soc_fpga_ram_arb_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 14,
    parameter int LOCKMAX   = LOCKMAX_DEFAULT
) (
    input  logic                 PortAClk,
    input  logic                 PortAReset,
    input  logic                 Req0Valid,
    output logic                 Req0Ready,
    input  logic [ADDRWIDTH-1:0] Req0Addr,
    output logic                 Rsp0Valid,
    output logic [DATAWIDTH-1:0] Rsp0Data,
    input  logic                 Req1Valid,
    output logic                 Req1Ready,
    input  logic                 Req1Write,
    input  logic [ADDRWIDTH-1:0] Req1Addr,
    input  logic [DATAWIDTH-1:0] Req1WData,
    input  logic                 Req1Lock,
    output logic                 Rsp1Valid,
    output logic [DATAWIDTH-1:0] Rsp1Data,
    output logic [ADDRWIDTH-1:0] PortAAddr,
    output logic [DATAWIDTH-1:0] PortADataIn,
    output logic                 PortAWriteEnable,
    input  logic [DATAWIDTH-1:0] PortADataOut
);

    localparam logic [DATAWIDTH-1:0] LP_ACK_DATA = DATAWIDTH'(WR_ACK_DATA);

    gnt_e w_gnt;
    logic w_last1;
    logic w_hold1;
    logic w_xfer0;
    logic w_xfer1;

    soc_fpga_rr_arb2 u_rr (
        .i_clk   (PortAClk),
        .i_rst   (PortAReset),
        .i_req0  (Req0Valid),
        .i_req1  (Req1Valid),
        .i_hold1 (w_hold1),
        .o_gnt   (w_gnt),
        .o_last1 (w_last1)
    );

    // The arbiter only grants a valid requester, so a grant is a transfer.
    assign w_xfer0   = (w_gnt == GNT_0);
    assign w_xfer1   = (w_gnt == GNT_1);
    assign Req0Ready = w_xfer0;
    assign Req1Ready = w_xfer1;

`ifdef SOC_FPGA_RAM_ARB_LOCK_EN
    localparam int LP_CNTW = $clog2(LOCKMAX + 1);

    // Consecutive locked loader transfers; saturates at LOCKMAX so the lock
    // releases and the fetch port gets the next conflict.
    logic [LP_CNTW-1:0] r_lock_cnt;
    logic               w_cnt_below_max;

    assign w_cnt_below_max = (r_lock_cnt < LP_CNTW'(LOCKMAX));

    always_ff @(posedge PortAClk or posedge PortAReset) begin
        if (PortAReset) begin
            r_lock_cnt <= '0;
        end else if (!Req1Lock || w_xfer0) begin
            r_lock_cnt <= '0;
        end else if (w_xfer1 && w_cnt_below_max) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    assign w_hold1 = Req1Lock && w_last1 && w_cnt_below_max;
`else
    logic w_unused_lock;

    assign w_unused_lock = ^{Req1Lock, w_last1, LOCKMAX[0]};
    assign w_hold1       = 1'b0;
`endif

    // RAM address holds its last granted value while idle.
    logic [ADDRWIDTH-1:0] r_addr_hold;

    always_comb begin
        PortAAddr        = r_addr_hold;
        PortADataIn      = '0;
        PortAWriteEnable = 1'b0;
        case (w_gnt)
            GNT_0: begin
                PortAAddr = Req0Addr;
            end
            GNT_1: begin
                PortAAddr        = Req1Addr;
                PortADataIn      = Req1Write ? Req1WData : '0;
                PortAWriteEnable = Req1Write;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge PortAClk or posedge PortAReset) begin
        if (PortAReset) begin
            r_addr_hold <= '0;
        end else if (w_gnt != GNT_NONE) begin
            r_addr_hold <= PortAAddr;
        end
    end

    // Response tracking. Reset clears these so a transfer made before reset
    // never produces a response afterwards.
    logic r_rsp0_vld;
    logic r_rsp1_vld;
    logic r_rsp1_wr;

    always_ff @(posedge PortAClk or posedge PortAReset) begin
        if (PortAReset) begin
            r_rsp0_vld <= 1'b0;
            r_rsp1_vld <= 1'b0;
            r_rsp1_wr  <= 1'b0;
        end else begin
            r_rsp0_vld <= w_xfer0;
            r_rsp1_vld <= w_xfer1;
            r_rsp1_wr  <= w_xfer1 && Req1Write;
        end
    end

    assign Rsp0Valid = r_rsp0_vld;
    assign Rsp1Valid = r_rsp1_vld;
    assign Rsp0Data  = r_rsp0_vld ? PortADataOut : '0;

    // The RAM holds its output across a write, so write acks carry the
    // constant ack value instead of stale read data.
    assign Rsp1Data  = !r_rsp1_vld ? '0 :
                       (r_rsp1_wr  ? LP_ACK_DATA : PortADataOut);

endmodule

// File: tb/tb_soc_fpga_ram_code_arb.sv
// Bench for soc_fpga_ram_code_arb: directed scenarios plus randomized traffic
// checked against a queue-based reference model and a response scoreboard.
// A behavioural RAM with registered read data sits on port A.
module tb_soc_fpga_ram_code_arb;

    localparam int DW     = 32;
    localparam int AW     = 14;
    localparam int LOCKMX = 4;

    logic          clk;
    logic          PortAReset;
    logic          Req0Valid;
    logic          Req0Ready;
    logic [AW-1:0] Req0Addr;
    logic          Rsp0Valid;
    logic [DW-1:0] Rsp0Data;
    logic          Req1Valid;
    logic          Req1Ready;
    logic          Req1Write;
    logic [AW-1:0] Req1Addr;
    logic [DW-1:0] Req1WData;
    logic          Req1Lock;
    logic          Rsp1Valid;
    logic [DW-1:0] Rsp1Data;
    logic [AW-1:0] PortAAddr;
    logic [DW-1:0] PortADataIn;
    logic          PortAWriteEnable;
    logic [DW-1:0] PortADataOut;

    soc_fpga_ram_code_arb #(
        .DATAWIDTH (DW),
        .ADDRWIDTH (AW),
        .LOCKMAX   (LOCKMX)
    ) dut (
        .PortAClk         (clk),
        .PortAReset       (PortAReset),
        .Req0Valid        (Req0Valid),
        .Req0Ready        (Req0Ready),
        .Req0Addr         (Req0Addr),
        .Rsp0Valid        (Rsp0Valid),
        .Rsp0Data         (Rsp0Data),
        .Req1Valid        (Req1Valid),
        .Req1Ready        (Req1Ready),
        .Req1Write        (Req1Write),
        .Req1Addr         (Req1Addr),
        .Req1WData        (Req1WData),
        .Req1Lock         (Req1Lock),
        .Rsp1Valid        (Rsp1Valid),
        .Rsp1Data         (Rsp1Data),
        .PortAAddr        (PortAAddr),
        .PortADataIn      (PortADataIn),
        .PortAWriteEnable (PortAWriteEnable),
        .PortADataOut     (PortADataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Power-on RAM contents; word 0x10 is the preloaded fetch target.
    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 16) return 32'hDEADBEEF;
        return 32'hA500_0000 ^ (a * 32'h0001_0203);
    endfunction

    // Behavioural RAM: write on WE, otherwise register the read word.
    logic [DW-1:0] ram    [0:(1<<AW)-1];
    bit            ram_wr [0:(1<<AW)-1];
    initial PortADataOut = '0;
    always @(posedge clk) begin
        if (PortAWriteEnable) begin
            ram[PortAAddr]    <= PortADataIn;
            ram_wr[PortAAddr] <= 1'b1;
        end else begin
            PortADataOut <= ram_wr[PortAAddr] ? ram[PortAAddr] : init_val(int'(PortAAddr));
        end
    end

    // Reference model state.
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    int            m_last;       // requester that won the last transfer
    int            m_streak;     // consecutive locked requester-1 transfers
    logic [AW-1:0] m_hold_addr;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    // Scoreboard monitor: each response must arrive exactly on its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            while (q0.size() > 0 && q0[0].due < cyc) begin
                chk("rsp0_missing", 0, 1);
                void'(q0.pop_front());
            end
            while (q1.size() > 0 && q1[0].due < cyc) begin
                chk("rsp1_missing", 0, 1);
                void'(q1.pop_front());
            end
            if (Rsp0Valid) begin
                if (q0.size() == 0 || q0[0].due != cyc) chk("rsp0_unexpected", 1, 0);
                else chk("rsp0_data", Rsp0Data, q0.pop_front().data);
            end else begin
                chk("rsp0_idle_data", Rsp0Data, 0);
            end
            if (Rsp1Valid) begin
                if (q1.size() == 0 || q1[0].due != cyc) chk("rsp1_unexpected", 1, 0);
                else chk("rsp1_data", Rsp1Data, q1.pop_front().data);
            end else begin
                chk("rsp1_idle_data", Rsp1Data, 0);
            end
        end
    end

    // One cycle of stimulus; entered #1 after a rising edge, returns #1 after the next.
    // got: 0/1 = granted requester, 2 = none, 3 = both (illegal).
    task automatic do_cycle(input logic r, input logic v0, input logic [AW-1:0] a0,
                            input logic v1, input logic w1, input logic [AW-1:0] a1,
                            input logic [DW-1:0] d1, input logic lk, output int got);
        int            eg;
        bit            hold;
        logic [AW-1:0] ea;
        PortAReset = r;
        Req0Valid  = v0;
        Req0Addr   = a0;
        Req1Valid  = v1;
        Req1Write  = w1;
        Req1Addr   = a1;
        Req1WData  = d1;
        Req1Lock   = lk;
        if (r) begin
            q0.delete();
            q1.delete();
            m_last      = 1;
            m_streak    = 0;
            m_hold_addr = '0;
        end
        @(negedge clk);
        hold = 0;
`ifdef SOC_FPGA_RAM_ARB_LOCK_EN
        hold = lk && (m_last == 1) && (m_streak < LOCKMX);
`endif
        if (r)              eg = 2;
        else if (v0 && v1)  eg = (hold || m_last == 0) ? 1 : 0;
        else if (v0)        eg = 0;
        else if (v1)        eg = 1;
        else                eg = 2;
        got = (Req0Ready && Req1Ready) ? 3 : Req0Ready ? 0 : Req1Ready ? 1 : 2;
        chk("req0_ready", Req0Ready, eg == 0);
        chk("req1_ready", Req1Ready, eg == 1);
        ea = r ? '0 : (eg == 0) ? a0 : (eg == 1) ? a1 : m_hold_addr;
        chk("ram_addr", PortAAddr, ea);
        chk("ram_we", PortAWriteEnable, (eg == 1) && w1);
        chk("ram_din", PortADataIn, ((eg == 1) && w1) ? d1 : '0);
        if (!r) begin
            if (!lk) m_streak = 0;
            if (eg == 0) begin
                q0.push_back('{due: cyc + 1, data: model_mem[a0]});
                m_last      = 0;
                m_streak    = 0;
                m_hold_addr = a0;
            end else if (eg == 1) begin
                if (w1) begin
                    model_mem[a1] = d1;
                    q1.push_back('{due: cyc + 1, data: '0});
                end else begin
                    q1.push_back('{due: cyc + 1, data: model_mem[a1]});
                end
                m_last = 1;
                if (lk && m_streak < LOCKMX) m_streak++;
                m_hold_addr = a1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int g;
        do_cycle(1, 1, 14'h3, 1, 1, 14'h7, 32'hFFFF_FFFF, 1, g);
        do_cycle(1, 1, 14'h3, 1, 0, 14'h7, 32'h0, 0, g);
    endtask

    int g;
    int alt_exp[6];
    int lock_exp[6];

    initial begin
        for (int i = 0; i < (1 << AW); i++) model_mem[i] = init_val(i);
        PortAReset = 1'b1;
        Req0Valid  = 1'b0;
        Req0Addr   = '0;
        Req1Valid  = 1'b0;
        Req1Write  = 1'b0;
        Req1Addr   = '0;
        Req1WData  = '0;
        Req1Lock   = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1;

        // Reset with both valids high: no readies, RAM drive quiet.
        do_reset();

        // Lone fetch of the preloaded word is granted immediately.
        do_cycle(0, 1, 14'h10, 0, 0, 14'h0, 32'h0, 0, g);
        chk("fetch_alone_grant", g, 0);
        do_cycle(0, 0, 14'h0, 0, 0, 14'h0, 32'h0, 0, g);
        chk("idle_grant", g, 2);

        // Continuous conflict after reset alternates starting with requester 0.
        alt_exp = '{0, 1, 0, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_cycle(0, 1, 14'(i), 1, 0, 14'(i + 8), 32'h0, 0, g);
            chk("alternate_grant", g, alt_exp[i]);
        end

        // Loader write then fetch read-back of the same word.
        do_reset();
        do_cycle(0, 0, 14'h0, 1, 1, 14'h20, 32'h1234_5678, 0, g);
        chk("write_grant", g, 1);
        do_cycle(0, 1, 14'h20, 0, 0, 14'h0, 32'h0, 0, g);
        chk("readback_grant", g, 0);
        do_cycle(0, 0, 14'h0, 0, 0, 14'h0, 32'h0, 0, g);

        // Burst lock: requester 1 wins first, then keeps priority up to LOCKMAX.
`ifdef SOC_FPGA_RAM_ARB_LOCK_EN
        lock_exp = '{1, 1, 1, 1, 0, 1};
`else
        lock_exp = '{1, 0, 1, 0, 1, 0};
`endif
        do_reset();
        do_cycle(0, 1, 14'h1, 0, 0, 14'h0, 32'h0, 0, g);
        for (int i = 0; i < 6; i++) begin
            do_cycle(0, 1, 14'(i + 2), 1, 0, 14'(i + 12), 32'h0, 1, g);
            chk("lock_grant", g, lock_exp[i]);
        end

        // Reset right after a read transfer drops its response.
        do_reset();
        do_cycle(0, 1, 14'h5, 0, 0, 14'h0, 32'h0, 0, g);
        do_cycle(1, 1, 14'h5, 1, 0, 14'h6, 32'h0, 0, g);
        do_cycle(0, 1, 14'h9, 1, 0, 14'hA, 32'h0, 0, g);
        chk("post_reset_conflict", g, 0);

        // Randomized traffic, occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic r, v0, v1, w1, lk;
            r  = ($urandom_range(0, 99) == 0);
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            w1 = $urandom_range(0, 1) == 1;
            lk = ($urandom_range(0, 7) != 0);
            do_cycle(r, v0, 14'($urandom_range(0, 31)), v1, w1,
                     14'($urandom_range(0, 31)), $urandom, lk, g);
            if (g == 3) chk("single_grant", 1, 0);
        end

        do_cycle(0, 0, 14'h0, 0, 0, 14'h0, 32'h0, 0, g);
        do_cycle(0, 0, 14'h0, 0, 0, 14'h0, 32'h0, 0, g);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
